// File: rtl/dtw_pkg.sv
// Shared definitions for the DTW traceback block: path codes, default
// sizing and the traceback FSM state type.
package dtw_pkg;

    // Default index width; the path buffer is 2^IDX_W x 2^IDX_W cells.
    localparam int IDX_W_DEF  = 4;
    // Path codes are always two bits wide.
    localparam int PATH_W_DEF = 2;

    // Path codes as produced by the PE array.
    localparam logic [1:0] PATH_DIAG = 2'b11;  // predecessor (i-1,j-1)
    localparam logic [1:0] PATH_UP   = 2'b10;  // predecessor (i-1,j)
    localparam logic [1:0] PATH_LEFT = 2'b01;  // predecessor (i,j-1)
    localparam logic [1:0] PATH_RST  = 2'b00;  // no valid predecessor

    // Traceback FSM states.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/dtw_path_mem.sv
// Path buffer: one path code per (i,j) cell, addressed as {i,j}.
// Single write port, single combinational read port, no reset.
module dtw_path_mem #(
    parameter int IDX_W  = 4,
    parameter int PATH_W = 2
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_i,
    input  logic [IDX_W-1:0]  wr_j,
    input  logic [PATH_W-1:0] wr_path,
    input  logic [IDX_W-1:0]  rd_i,
    input  logic [IDX_W-1:0]  rd_j,
    output logic [PATH_W-1:0] rd_path
);

    localparam int DEPTH = 2 ** (2 * IDX_W);

    logic [PATH_W-1:0] r_mem [DEPTH];

    // Store one path code per write strobe; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[{wr_i, wr_j}] <= wr_path;
        end
    end

    // The walker needs the code of the current cell in the same cycle.
    assign rd_path = r_mem[{rd_i, rd_j}];

endmodule

// File: rtl/dtw_traceback.sv
// DTW traceback: buffers the PE path codes, then walks back from
// (len_i,len_j) to (0,0), emitting one coordinate per valid/ready handshake.
module dtw_traceback
    import dtw_pkg::*;
#(
    parameter int IDX_W  = IDX_W_DEF,
    parameter int PATH_W = PATH_W_DEF
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_i,
    input  logic [IDX_W-1:0]  wr_j,
    input  logic [PATH_W-1:0] wr_path,
    input  logic              start,
    input  logic [IDX_W-1:0]  len_i,
    input  logic [IDX_W-1:0]  len_j,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_i,
    output logic [IDX_W-1:0]  out_j,
    output logic              out_last,
    output logic              err
);

    state_t            r_state;
    state_t            w_state_next;
    logic [IDX_W-1:0]  r_cur_i;
    logic [IDX_W-1:0]  r_cur_j;
    logic              r_err;
    logic [PATH_W-1:0] w_rd_path;
    logic [PATH_W-1:0] w_step;
    logic              w_wr_en;
    logic              w_at_origin;
    logic              w_hs;

    // The buffer is only writable between walks.
    assign w_wr_en = wr_en && (r_state == ST_IDLE);

    dtw_path_mem #(
        .IDX_W  (IDX_W),
        .PATH_W (PATH_W)
    ) u_path_mem (
        .clk     (clk),
        .wr_en   (w_wr_en),
        .wr_i    (wr_i),
        .wr_j    (wr_j),
        .wr_path (wr_path),
        .rd_i    (r_cur_i),
        .rd_j    (r_cur_j),
        .rd_path (w_rd_path)
    );

    assign w_at_origin = (r_cur_i == '0) && (r_cur_j == '0);
    assign w_hs        = (r_state == ST_EMIT) && out_ready;

    // Step code: on the first row/column the only legal move is along the
    // edge, which also keeps the decrement from ever wrapping.
    always_comb begin
        w_step = w_rd_path;
        if (r_cur_i == '0) begin
            w_step = PATH_LEFT;
        end else if (r_cur_j == '0) begin
            w_step = PATH_UP;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave EMIT after the origin is accepted or on a dead cell.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_hs && (w_at_origin || (w_step == PATH_RST))) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Walk position and sticky error: load on start, step on each handshake.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_cur_i <= '0;
            r_cur_j <= '0;
            r_err   <= 1'b0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_cur_i <= len_i;
            r_cur_j <= len_j;
            r_err   <= 1'b0;
        end else if (w_hs && !w_at_origin) begin
            case (w_step)
                PATH_DIAG: begin
                    r_cur_i <= r_cur_i - IDX_W'(1);
                    r_cur_j <= r_cur_j - IDX_W'(1);
                end
                PATH_UP:   r_cur_i <= r_cur_i - IDX_W'(1);
                PATH_LEFT: r_cur_j <= r_cur_j - IDX_W'(1);
                default:   r_err   <= 1'b1;
            endcase
        end
    end

    assign busy      = (r_state == ST_EMIT);
    assign out_valid = (r_state == ST_EMIT);
    assign out_i     = r_cur_i;
    assign out_j     = r_cur_j;
    assign out_last  = (r_state == ST_EMIT) && w_at_origin;
    assign err       = r_err;

endmodule

// File: tb/tb_dtw_traceback.sv
// Directed self-checking bench for dtw_traceback.
module tb_dtw_traceback;

    logic       clk;
    logic       nrst;
    logic       wr_en;
    logic [3:0] wr_i;
    logic [3:0] wr_j;
    logic [1:0] wr_path;
    logic       start;
    logic [3:0] len_i;
    logic [3:0] len_j;
    logic       busy;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_i;
    logic [3:0] out_j;
    logic       out_last;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;

    dtw_traceback dut (
        .clk       (clk),
        .nrst      (nrst),
        .wr_en     (wr_en),
        .wr_i      (wr_i),
        .wr_j      (wr_j),
        .wr_path   (wr_path),
        .start     (start),
        .len_i     (len_i),
        .len_j     (len_j),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_i     (out_i),
        .out_j     (out_j),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus helpers: called at a negedge, return at the next negedge.
    task automatic wr_cell(input int i, input int j, input logic [1:0] p);
        wr_en   = 1'b1;
        wr_i    = 4'(i);
        wr_j    = 4'(j);
        wr_path = p;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic fill_diag();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                wr_cell(i, j, 2'b11);
    endtask

    task automatic start_walk(input int li, input int lj);
        start = 1'b1;
        len_i = 4'(li);
        len_j = 4'(lj);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        #3;
        n_checks++;
        if ({busy, out_valid, out_last, err} !== 4'b0000) begin
            n_errors++;
            $display("FAIL reset_flags: busy/valid/last/err=%b required 0000", {busy, out_valid, out_last, err});
        end
        n_checks++;
        if ({out_i, out_j} !== 8'h00) begin
            n_errors++;
            $display("FAIL reset_coord: (%0d,%0d) required (0,0)", out_i, out_j);
        end
        @(negedge clk);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        $display("reset released, busy=%0b", busy);
    endtask

    task automatic test_diagonal();
        fill_diag();
        out_ready = 1'b1;
        start_walk(3, 3);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({out_valid, busy, out_i, out_j, out_last} !== {1'b1, 1'b1, 4'(3 - k), 4'(3 - k), (k == 3)}) begin
                n_errors++;
                $display("FAIL diag_step%0d: valid=%0b busy=%0b (%0d,%0d) last=%0b required valid=1 busy=1 (%0d,%0d) last=%0b",
                         k, out_valid, busy, out_i, out_j, out_last, 3 - k, 3 - k, k == 3);
            end
            $display("diag: out=(%0d,%0d) last=%0b", out_i, out_j, out_last);
            @(negedge clk);
        end
        n_checks++;
        if ({busy, out_valid, err} !== 3'b000) begin
            n_errors++;
            $display("FAIL diag_end: busy/valid/err=%b required 000", {busy, out_valid, err});
        end
    endtask

    task automatic test_mixed();
        int ei[5] = '{2, 2, 1, 0, 0};
        int ej[5] = '{3, 2, 2, 1, 0};
        wr_cell(2, 3, 2'b01);
        wr_cell(2, 2, 2'b10);
        wr_cell(1, 2, 2'b11);
        wr_cell(0, 1, 2'b00);  // must be overridden by the top-row forcing
        out_ready = 1'b1;
        start_walk(2, 3);
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({out_valid, out_i, out_j, out_last} !== {1'b1, 4'(ei[k]), 4'(ej[k]), (k == 4)}) begin
                n_errors++;
                $display("FAIL mixed_step%0d: valid=%0b (%0d,%0d) last=%0b required valid=1 (%0d,%0d) last=%0b",
                         k, out_valid, out_i, out_j, out_last, ei[k], ej[k], k == 4);
            end
            $display("mixed: out=(%0d,%0d) last=%0b", out_i, out_j, out_last);
            @(negedge clk);
        end
        n_checks++;
        if ({busy, out_valid, err} !== 3'b000) begin
            n_errors++;
            $display("FAIL mixed_end: busy/valid/err=%b required 000", {busy, out_valid, err});
        end
    endtask

    task automatic test_boundary();
        // Garbage along column 0 and row 0; forcing must ignore it.
        wr_cell(3, 0, 2'b11);
        wr_cell(2, 0, 2'b00);
        wr_cell(1, 0, 2'b01);
        wr_cell(0, 3, 2'b11);
        wr_cell(0, 2, 2'b00);
        wr_cell(0, 1, 2'b10);
        out_ready = 1'b1;
        for (int side = 0; side < 2; side++) begin
            start_walk(side == 0 ? 3 : 0, side == 0 ? 0 : 3);
            for (int k = 0; k < 4; k++) begin
                logic [3:0] ri;
                logic [3:0] rj;
                ri = (side == 0) ? 4'(3 - k) : 4'd0;
                rj = (side == 0) ? 4'd0 : 4'(3 - k);
                n_checks++;
                if ({out_valid, out_i, out_j, out_last} !== {1'b1, ri, rj, (k == 3)}) begin
                    n_errors++;
                    $display("FAIL edge%0d_step%0d: valid=%0b (%0d,%0d) last=%0b required valid=1 (%0d,%0d) last=%0b",
                             side, k, out_valid, out_i, out_j, out_last, ri, rj, k == 3);
                end
                $display("edge%0d: out=(%0d,%0d) last=%0b", side, out_i, out_j, out_last);
                @(negedge clk);
            end
            n_checks++;
            if ({busy, out_valid, err} !== 3'b000) begin
                n_errors++;
                $display("FAIL edge%0d_end: busy/valid/err=%b required 000", side, {busy, out_valid, err});
            end
        end
    endtask

    task automatic test_backpressure();
        logic pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int   k;
        int   cyc;
        fill_diag();
        out_ready = 1'b0;
        start_walk(3, 3);
        k   = 0;
        cyc = 0;
        while (k < 4 && cyc < 30) begin
            n_checks++;
            if ({out_valid, out_i, out_j, out_last} !== {1'b1, 4'(3 - k), 4'(3 - k), (k == 3)}) begin
                n_errors++;
                $display("FAIL bp_cyc%0d: valid=%0b (%0d,%0d) last=%0b required valid=1 (%0d,%0d) last=%0b",
                         cyc, out_valid, out_i, out_j, out_last, 3 - k, 3 - k, k == 3);
            end
            out_ready = pat[cyc % 4];
            $display("bp: cyc=%0d out=(%0d,%0d) ready=%0b", cyc, out_i, out_j, out_ready);
            @(negedge clk);
            if (out_ready) k++;
            cyc++;
        end
        out_ready = 1'b1;
        n_checks++;
        if (k != 4) begin
            n_errors++;
            $display("FAIL bp_count: handshakes=%0d required 4", k);
        end
        n_checks++;
        if ({busy, out_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL bp_end: busy/valid=%b required 00", {busy, out_valid});
        end
    endtask

    task automatic test_error();
        wr_cell(2, 2, 2'b11);
        wr_cell(1, 1, 2'b00);
        out_ready = 1'b1;
        start_walk(2, 2);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({out_valid, out_i, out_j, out_last, err} !== {1'b1, 4'(2 - k), 4'(2 - k), 1'b0, 1'b0}) begin
                n_errors++;
                $display("FAIL err_step%0d: valid=%0b (%0d,%0d) last=%0b err=%0b required valid=1 (%0d,%0d) last=0 err=0",
                         k, out_valid, out_i, out_j, out_last, err, 2 - k, 2 - k);
            end
            $display("err: out=(%0d,%0d) err=%0b", out_i, out_j, err);
            @(negedge clk);
        end
        n_checks++;
        if ({err, out_valid, busy} !== 3'b100) begin
            n_errors++;
            $display("FAIL err_flag: err/valid/busy=%b required 100", {err, out_valid, busy});
        end
        // A new start clears err; a zero-length walk emits only the origin.
        wr_cell(1, 1, 2'b11);
        start_walk(0, 0);
        n_checks++;
        if ({err, out_valid, out_i, out_j, out_last} !== {1'b0, 1'b1, 4'd0, 4'd0, 1'b1}) begin
            n_errors++;
            $display("FAIL zero_len: err=%0b valid=%0b (%0d,%0d) last=%0b required err=0 valid=1 (0,0) last=1",
                     err, out_valid, out_i, out_j, out_last);
        end
        $display("zero: out=(%0d,%0d) last=%0b err=%0b", out_i, out_j, out_last, err);
        @(negedge clk);
        n_checks++;
        if ({busy, out_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL zero_end: busy/valid=%b required 00", {busy, out_valid});
        end
    endtask

    task automatic test_ignored_inputs();
        out_ready = 1'b0;
        start_walk(3, 3);
        // Both pulses arrive while busy and must be dropped.
        wr_en   = 1'b1;
        wr_i    = 4'd2;
        wr_j    = 4'd2;
        wr_path = 2'b00;
        start   = 1'b1;
        len_i   = 4'd1;
        len_j   = 4'd1;
        @(negedge clk);
        wr_en = 1'b0;
        start = 1'b0;
        n_checks++;
        if ({out_valid, out_i, out_j} !== {1'b1, 4'd3, 4'd3}) begin
            n_errors++;
            $display("FAIL ign_start: valid=%0b (%0d,%0d) required valid=1 (3,3)", out_valid, out_i, out_j);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if ({out_valid, out_i, out_j, err} !== {1'b1, 4'(3 - k), 4'(3 - k), 1'b0}) begin
                n_errors++;
                $display("FAIL ign_step%0d: valid=%0b (%0d,%0d) err=%0b required valid=1 (%0d,%0d) err=0",
                         k, out_valid, out_i, out_j, err, 3 - k, 3 - k);
            end
            $display("ign: out=(%0d,%0d) err=%0b", out_i, out_j, err);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_walk();
        out_ready = 1'b1;
        start_walk(3, 3);
        @(negedge clk);  // now presenting the 2nd coordinate
        n_checks++;
        if ({out_valid, out_i, out_j} !== {1'b1, 4'd2, 4'd2}) begin
            n_errors++;
            $display("FAIL rst_pre: valid=%0b (%0d,%0d) required valid=1 (2,2)", out_valid, out_i, out_j);
        end
        #1 nrst = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, err, out_last, out_i, out_j} !== {4'b0000, 4'd0, 4'd0}) begin
            n_errors++;
            $display("FAIL rst_async: valid=%0b busy=%0b err=%0b last=%0b (%0d,%0d) required all 0",
                     out_valid, busy, err, out_last, out_i, out_j);
        end
        $display("rst mid-walk: valid=%0b busy=%0b", out_valid, busy);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({busy, out_valid} !== 2'b00) begin
            n_errors++;
            $display("FAIL rst_stay_idle: busy/valid=%b required 00", {busy, out_valid});
        end
    endtask

    initial begin
        wr_en     = 1'b0;
        wr_i      = '0;
        wr_j      = '0;
        wr_path   = '0;
        start     = 1'b0;
        len_i     = '0;
        len_j     = '0;
        out_ready = 1'b0;
        test_reset();
        test_diagonal();
        test_mixed();
        test_boundary();
        test_backpressure();
        test_error();
        test_ignored_inputs();
        test_reset_mid_walk();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dtw_traceback.md
Name: dtw_traceback

Overview:
Consumes the 2-bit o_path codes produced by the DTW processing-element array and stores them in a per-cell path buffer. On command, it walks back from cell (len_i,len_j) to (0,0) and emits the optimal warping path one coordinate pair per valid/ready handshake. It sits directly downstream of the PE array, in parallel with the final distance readout.

Parameters:
IDX_W, 4, width of the i and j indices; buffer holds 2^IDX_W x 2^IDX_W cells
PATH_W, 2, width of a path code (fixed at 2; exposed for the package)

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
wr_en  in  1  write one path code into the buffer
wr_i  in  IDX_W  row index (T axis) of the written cell
wr_j  in  IDX_W  column index (R axis) of the written cell
wr_path  in  2  path code from the PE: 11 diag (i-1,j-1), 10 (i-1,j), 01 (i,j-1), 00 invalid
start  in  1  begin traceback (1-cycle pulse)
len_i  in  IDX_W  last row index (end cell i)
len_j  in  IDX_W  last column index (end cell j)
busy  out  1  traceback in progress
out_valid  out  1  coordinate available
out_ready  in  1  consumer accepts coordinate
out_i  out  IDX_W  current path row
out_j  out  IDX_W  current path column
out_last  out  1  current coordinate is (0,0)
err  out  1  sticky: invalid code (00) met off-origin

Behaviour:
- Reset is asynchronous and active-low. While nrst=0: state=IDLE; busy, out_valid, out_last and err are 0; out_i and out_j are 0. Buffer contents are not reset; cells are undefined until written.
- Buffer: 1 write port, 1 combinational read port at (cur_i,cur_j). wr_en is honoured only in IDLE and is ignored while busy. A write takes effect at the next edge.
- FSM states: IDLE, EMIT.
- IDLE -> EMIT: start=1 on a rising edge. cur_i<=len_i, cur_j<=len_j, err<=0, busy<=1. out_valid rises on the edge after start (latency 1).
- A start pulse seen while in EMIT is ignored.
- EMIT: out_valid=1, out_i=cur_i, out_j=cur_j, out_last=(cur_i==0 && cur_j==0). The outputs are held stable while out_valid=1 and out_ready=0.
- Handshake (out_valid & out_ready on an edge), when out_last=1: go to IDLE; busy<=0, out_valid<=0.
- Handshake, otherwise, the step code is determined as follows:
  - cur_i==0: forced 01.
  - cur_j==0: forced 10.
  - otherwise: buffer[cur_i][cur_j].
- Step action per code:
  - 11: cur_i-1, cur_j-1.
  - 10: cur_i-1.
  - 01: cur_j-1.
  - 00: err<=1, go to IDLE, busy<=0, out_valid<=0. No further coordinates are emitted.
- Throughput: one coordinate per cycle when out_ready is held high.
- Path length: max(len_i,len_j)+1 <= count <= len_i+len_j+1.
- start with len_i=len_j=0: emits a single (0,0) with out_last=1.
- Index decrement never wraps; the boundary forcing above guarantees this.
- Reset mid-walk: returns immediately to IDLE with outputs cleared. A new start is required to restart the walk.
- The buffer may be rewritten in IDLE between walks; no clear operation is needed.

Decomposition:
- Package dtw_pkg holds:
  - path code constants PATH_DIAG=2'b11, PATH_UP=2'b10, PATH_LEFT=2'b01, PATH_RST=2'b00, matching the PE encoding;
  - the default IDX_W;
  - the FSM state enum.
- Sub-module dtw_path_mem: a 2^(2*IDX_W) x 2 register array with 1 write port and 1 combinational read port, no reset. Address is {i,j}.
- The FSM and step logic stay in dtw_traceback.

Test Plan:
- Diagonal walk: write 11 to all cells of a 4x4 grid, start with len=(3,3), out_ready=1 -> emits (3,3),(2,2),(1,1),(0,0) on consecutive cycles; out_last only on the 4th; busy drops the cycle after.
- Mixed path: (2,3)=01, (2,2)=10, (1,2)=11, (0,1)=forced; start len=(2,3) -> emits (2,3),(2,2),(1,2),(0,1),(0,0).
- Boundary forcing: len=(3,0) with garbage in buffer -> emits (3,0),(2,0),(1,0),(0,0), err=0. Same for len=(0,3) along the top row.
- Backpressure: diagonal walk with out_ready toggling 1,0,0,1 -> coordinates are held stable while stalled; no skips or duplicates; total 4 handshakes.
- Error: (2,2)=11, (1,1)=00, start len=(2,2) -> emits (2,2),(1,1); on the (1,1) handshake err=1, out_valid=0, busy=0. The next start clears err.
- Reset/ignored inputs:
  - Assert nrst low during the 2nd coordinate -> out_valid, busy and err go 0 asynchronously.
  - start and wr_en pulsed while busy -> no effect on the walk or the buffer.
